// File: rtl/alu_issue_stage.sv
// RV32I execute-stage front end: ID/EX register, ALU op decode and operand selection.
// Define ALU_ISSUE_FORWARDING_EN to enable EX/MEM and MEM/WB forwarding with hold refresh.
package alu_issue_pkg;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_sel_e;

  typedef enum logic [1:0] {OP1_ZERO = 2'd0, OP1_RS1 = 2'd1, OP1_PC = 2'd2} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO = 2'd0, OP2_RS2 = 2'd1, OP2_IMM = 2'd2, OP2_FOUR = 2'd3} op2_sel_e;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_5_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [4:0]            rs2_addr_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  exmem_regwrite_i,
  input  logic [4:0]            exmem_rd_i,
  input  logic [DATA_WIDTH-1:0] exmem_result_i,
  input  logic                  memwb_regwrite_i,
  input  logic [4:0]            memwb_rd_i,
  input  logic [DATA_WIDTH-1:0] memwb_result_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output alu_sel_e              ALUSel_o,
  output logic [DATA_WIDTH-1:0] operand1_o,
  output logic [DATA_WIDTH-1:0] operand2_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [4:0]            rd_addr_o,
  output logic                  illegal_o
);

  logic                  r_valid;
  alu_sel_e              r_alu_sel;
  op1_sel_e              r_op1_sel;
  op2_sel_e              r_op2_sel;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [4:0]            r_rs1_addr;
  logic [4:0]            r_rs2_addr;
  logic [4:0]            r_rd_addr;
  logic                  r_illegal;

  alu_sel_e              w_alu_sel;
  op1_sel_e              w_op1_sel;
  op2_sel_e              w_op2_sel;
  logic                  w_illegal;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_rs1_fwd;
  logic [DATA_WIDTH-1:0] w_rs2_fwd;

  assign id_ready_o = !r_valid || ex_ready_i;
  assign w_load     = id_valid_i && id_ready_o && !flush_i;

  always_comb begin
    w_alu_sel = ALU_ADD;
    w_op1_sel = OP1_ZERO;
    w_op2_sel = OP2_ZERO;
    w_illegal = 1'b0;
    case (opcode_i)
      7'b0110011, 7'b0010011: begin
        w_op1_sel = OP1_RS1;
        w_op2_sel = (opcode_i == 7'b0110011) ? OP2_RS2 : OP2_IMM;
        case (funct3_i)
          // funct7_5 is an immediate bit for ADDI, so only register-register ops may subtract
          3'b000:  w_alu_sel = ((opcode_i == 7'b0110011) && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  w_alu_sel = ALU_SLL;
          3'b010:  w_alu_sel = ALU_SLT;
          3'b011:  w_alu_sel = ALU_SLTU;
          3'b100:  w_alu_sel = ALU_XOR;
          3'b101:  w_alu_sel = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_sel = ALU_OR;
          3'b111:  w_alu_sel = ALU_AND;
          default: w_alu_sel = ALU_ADD;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_IMM;
      end
      7'b0110111: begin
        w_alu_sel = ALU_PASS_B;
        w_op2_sel = OP2_IMM;
      end
      7'b0010111: begin
        w_op1_sel = OP1_PC;
        w_op2_sel = OP2_IMM;
      end
      7'b1101111, 7'b1100111: begin
        w_op1_sel = OP1_PC;
        w_op2_sel = OP2_FOUR;
      end
      7'b1100011: begin
        w_alu_sel = ALU_SUB;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_RS2;
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_ISSUE_FORWARDING_EN
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [4:0]            addr,
    input logic [DATA_WIDTH-1:0] latched
  );
    if (exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == addr)) begin
      return exmem_result_i;
    end else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == addr)) begin
      return memwb_result_i;
    end else begin
      return latched;
    end
  endfunction

  assign w_rs1_fwd = fwd_sel(r_rs1_addr, r_rs1_data);
  assign w_rs2_fwd = fwd_sel(r_rs2_addr, r_rs2_data);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_regwrite_i, exmem_rd_i, exmem_result_i,
                          memwb_regwrite_i, memwb_rd_i, memwb_result_i,
                          r_rs1_addr, r_rs2_addr};
  assign w_rs1_fwd = r_rs1_data;
  assign w_rs2_fwd = r_rs2_data;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_alu_sel  <= ALU_ADD;
      r_op1_sel  <= OP1_ZERO;
      r_op2_sel  <= OP2_ZERO;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_rd_addr  <= 5'd0;
      r_illegal  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_alu_sel  <= w_alu_sel;
      r_op1_sel  <= w_op1_sel;
      r_op2_sel  <= w_op2_sel;
      r_pc       <= pc_i;
      r_rs1_data <= rs1_data_i;
      r_rs2_data <= rs2_data_i;
      r_imm      <= imm_i;
      r_rs1_addr <= rs1_addr_i;
      r_rs2_addr <= rs2_addr_i;
      r_rd_addr  <= rd_addr_i;
      r_illegal  <= w_illegal;
    end else if (r_valid && !ex_ready_i) begin
      // capture forwarded values so a producer retiring during the stall is not lost
      r_rs1_data <= w_rs1_fwd;
      r_rs2_data <= w_rs2_fwd;
    end else begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    case (r_op1_sel)
      OP1_RS1: operand1_o = w_rs1_fwd;
      OP1_PC:  operand1_o = r_pc;
      default: operand1_o = '0;
    endcase
    case (r_op2_sel)
      OP2_RS2:  operand2_o = w_rs2_fwd;
      OP2_IMM:  operand2_o = r_imm;
      OP2_FOUR: operand2_o = DATA_WIDTH'(4);
      default:  operand2_o = '0;
    endcase
  end

  assign store_data_o = w_rs2_fwd;
  assign ex_valid_o   = r_valid;
  assign ALUSel_o     = r_alu_sel;
  assign rd_addr_o    = r_rd_addr;
  assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed issues push expectations, a monitor pops on consume.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_i, rst_i, flush_i, id_valid_i, id_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        funct7_5_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic        ex_valid_o, ex_ready_i;
  alu_sel_e    ALUSel_o;
  logic [31:0] operand1_o, operand2_o, store_data_o;
  logic [4:0]  rd_addr_o;
  logic        illegal_o;

  typedef struct packed {
    alu_sel_e    sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  alu_issue_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_5_i(funct7_5_i),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ALUSel_o(ALUSel_o), .operand1_o(operand1_o), .operand2_o(operand2_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .illegal_o(illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic exp_t mk(input alu_sel_e s, input logic [31:0] o1, input logic [31:0] o2,
                              input logic [31:0] st, input logic [4:0] rd, input logic il);
    exp_t e;
    e.sel = s; e.op1 = o1; e.op2 = o2; e.store = st; e.rd = rd; e.ill = il;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one beat at posedge+1; expectation is queued only if it should reach the ALU
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [31:0] pc, input logic [31:0] r1d, input logic [31:0] r2d,
                       input logic [31:0] imm, input logic [4:0] r1a, input logic [4:0] r2a,
                       input logic [4:0] rd, input exp_t e, input bit push);
    opcode_i = opc; funct3_i = f3; funct7_5_i = f75; pc_i = pc;
    rs1_data_i = r1d; rs2_data_i = r2d; imm_i = imm;
    rs1_addr_i = r1a; rs2_addr_i = r2a; rd_addr_i = rd;
    id_valid_i = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk_i); #1;
    id_valid_i = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk_i); #1;
    @(posedge clk_i); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(ex_valid_o), 32'd0);
    check({tag, "_ready"}, 32'(id_ready_o), 32'd1);
    check({tag, "_sel"},   32'(ALUSel_o), 32'(ALU_ADD));
    check({tag, "_op1"},   operand1_o, 32'd0);
    check({tag, "_op2"},   operand2_o, 32'd0);
    check({tag, "_store"}, store_data_o, 32'd0);
    check({tag, "_rd"},    32'(rd_addr_o), 32'd0);
    check({tag, "_ill"},   32'(illegal_o), 32'd0);
  endtask

  // Monitor: every consumed beat must match the oldest queued expectation
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk_i);
      if (!rst_i && ex_valid_o && ex_ready_i) begin
        n_vec++;
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_issue: got op1 %h op2 %h rd %0d expected no beat",
                   operand1_o, operand2_o, rd_addr_o);
        end else begin
          e = q.pop_front();
          act = mk(ALUSel_o, operand1_o, operand2_o, store_data_o, rd_addr_o, illegal_o);
          if (act !== e) begin
            n_miss++;
            $display("FAIL issue_rd%0d: got %h expected %h", e.rd, act, e);
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
    opcode_i = 7'd0; funct3_i = 3'd0; funct7_5_i = 1'b0;
    pc_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0; imm_i = 32'd0;
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; rd_addr_i = 5'd0;
    exmem_regwrite_i = 1'b0; exmem_rd_i = 5'd0; exmem_result_i = 32'd0;
    memwb_regwrite_i = 1'b0; memwb_rd_i = 5'd0; memwb_result_i = 32'd0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_reset_outputs("reset");

    // back-to-back decode vectors, no forwarding match
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3,
          mk(ALU_ADD, 32'd5, 32'd7, 32'd7, 5'd3, 1'b0), 1'b1);
    issue(7'b0110011, 3'b000, 1'b1, 32'h0, 32'd10, 32'd3, 32'h0, 5'd1, 5'd2, 5'd4,
          mk(ALU_SUB, 32'd10, 32'd3, 32'd3, 5'd4, 1'b0), 1'b1);
    issue(7'b0110011, 3'b001, 1'b0, 32'h0, 32'd1, 32'd5, 32'h0, 5'd1, 5'd2, 5'd5,
          mk(ALU_SLL, 32'd1, 32'd5, 32'd5, 5'd5, 1'b0), 1'b1);
    issue(7'b0110011, 3'b010, 1'b0, 32'h0, 32'd2, 32'd6, 32'h0, 5'd1, 5'd2, 5'd6,
          mk(ALU_SLT, 32'd2, 32'd6, 32'd6, 5'd6, 1'b0), 1'b1);
    issue(7'b0110011, 3'b011, 1'b0, 32'h0, 32'd3, 32'd7, 32'h0, 5'd1, 5'd2, 5'd7,
          mk(ALU_SLTU, 32'd3, 32'd7, 32'd7, 5'd7, 1'b0), 1'b1);
    issue(7'b0110011, 3'b100, 1'b0, 32'h0, 32'hF0, 32'h0F, 32'h0, 5'd1, 5'd2, 5'd8,
          mk(ALU_XOR, 32'hF0, 32'h0F, 32'h0F, 5'd8, 1'b0), 1'b1);
    issue(7'b0110011, 3'b101, 1'b1, 32'h0, 32'h80, 32'd2, 32'h0, 5'd1, 5'd2, 5'd9,
          mk(ALU_SRA, 32'h80, 32'd2, 32'd2, 5'd9, 1'b0), 1'b1);
    issue(7'b0110011, 3'b110, 1'b0, 32'h0, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd10,
          mk(ALU_OR, 32'h11, 32'h22, 32'h22, 5'd10, 1'b0), 1'b1);
    issue(7'b0110011, 3'b111, 1'b0, 32'h0, 32'h33, 32'h44, 32'h0, 5'd1, 5'd2, 5'd11,
          mk(ALU_AND, 32'h33, 32'h44, 32'h44, 5'd11, 1'b0), 1'b1);
    issue(7'b0010011, 3'b101, 1'b1, 32'h0, 32'h8000_0000, 32'h99, 32'd4, 5'd1, 5'd2, 5'd12,
          mk(ALU_SRA, 32'h8000_0000, 32'd4, 32'h99, 5'd12, 1'b0), 1'b1);
    issue(7'b0010011, 3'b101, 1'b0, 32'h0, 32'h8000_0000, 32'h99, 32'd4, 5'd1, 5'd2, 5'd13,
          mk(ALU_SRL, 32'h8000_0000, 32'd4, 32'h99, 5'd13, 1'b0), 1'b1);
    issue(7'b0010011, 3'b000, 1'b1, 32'h0, 32'd10, 32'd1, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd14,
          mk(ALU_ADD, 32'd10, 32'hFFFF_FFFF, 32'd1, 5'd14, 1'b0), 1'b1);
    issue(7'b0000011, 3'b010, 1'b0, 32'h0, 32'h1000, 32'd1, 32'd8, 5'd1, 5'd2, 5'd15,
          mk(ALU_ADD, 32'h1000, 32'd8, 32'd1, 5'd15, 1'b0), 1'b1);
    issue(7'b0100011, 3'b010, 1'b0, 32'h0, 32'h2000, 32'hDEAD, 32'hC, 5'd1, 5'd2, 5'd0,
          mk(ALU_ADD, 32'h2000, 32'hC, 32'hDEAD, 5'd0, 1'b0), 1'b1);
    issue(7'b0110111, 3'b000, 1'b0, 32'h0, 32'h77, 32'd2, 32'h1234_5000, 5'd1, 5'd2, 5'd16,
          mk(ALU_PASS_B, 32'd0, 32'h1234_5000, 32'd2, 5'd16, 1'b0), 1'b1);
    issue(7'b0010111, 3'b000, 1'b0, 32'h400, 32'h77, 32'd2, 32'h1000, 5'd1, 5'd2, 5'd17,
          mk(ALU_ADD, 32'h400, 32'h1000, 32'd2, 5'd17, 1'b0), 1'b1);
    issue(7'b1101111, 3'b000, 1'b0, 32'h100, 32'h77, 32'd2, 32'h40, 5'd1, 5'd2, 5'd1,
          mk(ALU_ADD, 32'h100, 32'd4, 32'd2, 5'd1, 1'b0), 1'b1);
    issue(7'b1100111, 3'b000, 1'b0, 32'h200, 32'h77, 32'd2, 32'h40, 5'd1, 5'd2, 5'd18,
          mk(ALU_ADD, 32'h200, 32'd4, 32'd2, 5'd18, 1'b0), 1'b1);
    issue(7'b1100011, 3'b000, 1'b0, 32'h300, 32'd9, 32'd9, 32'h40, 5'd1, 5'd2, 5'd0,
          mk(ALU_SUB, 32'd9, 32'd9, 32'd9, 5'd0, 1'b0), 1'b1);
    issue(7'b1111111, 3'b000, 1'b0, 32'h300, 32'd5, 32'd6, 32'h40, 5'd1, 5'd2, 5'd19,
          mk(ALU_ADD, 32'd0, 32'd0, 32'd6, 5'd19, 1'b1), 1'b1);
    settle();

    // forwarding priority on rs1 = x4
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd4; exmem_result_i = 32'hAA;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd4; memwb_result_i = 32'hBB;
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'h11, 32'h22, 32'h0, 5'd4, 5'd2, 5'd6,
          mk(ALU_ADD, FWD ? 32'hAA : 32'h11, 32'h22, 32'h22, 5'd6, 1'b0), 1'b1);
    settle();
    exmem_regwrite_i = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'h11, 32'h22, 32'h0, 5'd4, 5'd2, 5'd6,
          mk(ALU_ADD, FWD ? 32'hBB : 32'h11, 32'h22, 32'h22, 5'd6, 1'b0), 1'b1);
    settle();
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'h33, 32'h22, 32'h0, 5'd0, 5'd2, 5'd6,
          mk(ALU_ADD, 32'h33, 32'h22, 32'h22, 5'd6, 1'b0), 1'b1);
    settle();
    exmem_regwrite_i = 1'b0; memwb_rd_i = 5'd2; memwb_result_i = 32'hCC;
    issue(7'b0100011, 3'b010, 1'b0, 32'h0, 32'h500, 32'h22, 32'h4, 5'd1, 5'd2, 5'd0,
          mk(ALU_ADD, 32'h500, 32'h4, FWD ? 32'hCC : 32'h22, 5'd0, 1'b0), 1'b1);
    settle();
    memwb_regwrite_i = 1'b0; memwb_rd_i = 5'd0;

    // hold refresh: MEM/WB producer visible only in the first stall cycle
    ex_ready_i = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'h11, 32'd1, 32'h0, 5'd4, 5'd2, 5'd7,
          mk(ALU_ADD, FWD ? 32'h55 : 32'h11, 32'd1, 32'd1, 5'd7, 1'b0), 1'b1);
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd4; memwb_result_i = 32'h55;
    @(posedge clk_i); #1;
    memwb_regwrite_i = 1'b0;
    check("hold_op1_a", operand1_o, FWD ? 32'h55 : 32'h11);
    check("hold_valid", 32'(ex_valid_o), 32'd1);
    check("hold_ready", 32'(id_ready_o), 32'd0);
    @(posedge clk_i); #1;
    check("hold_op1_b", operand1_o, FWD ? 32'h55 : 32'h11);
    check("hold_rd", 32'(rd_addr_o), 32'd7);
    ex_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("hold_released", 32'(ex_valid_o), 32'd0);

    // flush with a held entry plus an incoming beat, then flush of an accepted beat
    ex_ready_i = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd1, 5'd2, 5'd20,
          mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0), 1'b0);
    flush_i = 1'b1;
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'd2, 32'd2, 32'h0, 5'd1, 5'd2, 5'd21,
          mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0), 1'b0);
    flush_i = 1'b0;
    check("flush_held", 32'(ex_valid_o), 32'd0);
    check("flush_ready", 32'(id_ready_o), 32'd1);
    flush_i = 1'b1;
    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'd3, 32'd3, 32'h0, 5'd1, 5'd2, 5'd22,
          mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0), 1'b0);
    flush_i = 1'b0;
    check("flush_accepted", 32'(ex_valid_o), 32'd0);
    ex_ready_i = 1'b1;
    settle();

    // asynchronous reset mid-stream
    ex_ready_i = 1'b0;
    issue(7'b0010111, 3'b000, 1'b1, 32'h440, 32'd1, 32'd2, 32'h10, 5'd1, 5'd2, 5'd23,
          mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0), 1'b0);
    check("pre_reset_valid", 32'(ex_valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ex_ready_i = 1'b1;
    check_reset_outputs("post_rst");

    issue(7'b0110011, 3'b000, 1'b0, 32'h0, 32'd40, 32'd2, 32'h0, 5'd1, 5'd2, 5'd24,
          mk(ALU_ADD, 32'd40, 32'd2, 32'd2, 5'd24, 1'b0), 1'b1);
    settle();
    settle();

    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
